sha3_padder: RTL and testbench

Sequential message padder for the low-throughput SHA-3 core. It accepts the message as 32-bit words and uses the combinational `padder1` to insert the domain byte into the final partial word. It appends zero words and the closing 0x80 bit, and presents complete 576-bit rate blocks (SHA3-512) to the permutation stage through a full/acknowledge handshake.

---
 rtl/sha3_padder_pkg.sv | 18 +
 rtl/sha3_padder_if.sv | 30 +++
 rtl/sha3_padder_padder1.sv | 31 +++
 rtl/sha3_padder.sv | 98 +++++++++
 tb/tb_sha3_padder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_padder_pkg.sv
// sha3_pkg: shared constants and types for the SHA-3 message padder.
//   RATE_WORDS  - 32-bit words per SHA3-512 rate block (576 bits)
//   DOMAIN_BYTE - SHA-3 domain separation byte inserted after the message
//   FINAL_BIT   - closing pad bit, lives in the low byte of the last rate word
//   state_t     - padder FSM encoding
package sha3_pkg;

  localparam int RATE_WORDS = 18;
  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
  localparam logic [31:0] FINAL_BIT = 32'h00000080;

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sha3_padder_if.sv
// sha3_padder_if: message-in / block-out handshake of the SHA-3 padder.
//   in, in_ready, is_last, byte_num - message word from the source
//   buffer_full                     - block register full, source must hold its word
//   out, out_ready                  - complete rate block for the permutation
//   f_ack                           - permutation has consumed the block
// The master modport is the source/permutation side, slave is the padder.
interface sha3_padder_if #(
  parameter int RATE_WORDS = sha3_pkg::RATE_WORDS
);

  logic [31:0]              in;
  logic                     in_ready;
  logic                     is_last;
  logic [1:0]               byte_num;
  logic                     buffer_full;
  logic [32*RATE_WORDS-1:0] out;
  logic                     out_ready;
  logic                     f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );

endinterface

// File: rtl/sha3_padder_padder1.sv
// padder1: combinational domain-byte inserter for the final message word.
//   in_i       - final message word, byte 0 in [31:24]
//   byte_num_i - number of valid message bytes in in_i (0..3)
//   out_o      - valid bytes kept, domain byte placed right after them,
//                remaining bytes zero
module padder1
  import sha3_pkg::*;
(
  input  logic [31:0] in_i,
  input  logic [1:0]  byte_num_i,
  output logic [31:0] out_o
);

  logic [31:0] keepMask;
  logic [31:0] domainWord;

  // Keep the valid leading bytes and slide the domain byte down behind them.
  always_comb begin
    keepMask = 32'h0;
    case (byte_num_i)
      2'd0: keepMask = 32'h00000000;
      2'd1: keepMask = 32'hFF000000;
      2'd2: keepMask = 32'hFFFF0000;
      2'd3: keepMask = 32'hFFFFFF00;
      default: keepMask = 32'h0;
    endcase
    domainWord = {DOMAIN_BYTE, 24'h0} >> {byte_num_i, 3'b000};
    out_o = (in_i & keepMask) | domainWord;
  end

endmodule

// File: rtl/sha3_padder.sv
// sha3_padder: sequential SHA-3 message padder (one message per reset).
//   clk   - clock
//   reset - asynchronous active-high reset, discards any partial block
//   bus   - slave side of sha3_padder_if (message words in, rate block out)
// Words shift into a RATE_WORDS-deep block register. The last word gets the
// domain byte, zero words fill the rest of the block, and the final 0x80 bit
// is ORed into whichever write lands in the last slot.
module sha3_padder #(
  parameter int RATE_WORDS = sha3_pkg::RATE_WORDS
) (
  input logic         clk,
  input logic         reset,
  sha3_padder_if.slave bus
);

  import sha3_pkg::*;

  localparam int BLOCK_BITS = 32 * RATE_WORDS;
  localparam int COUNT_BITS = $clog2(RATE_WORDS + 1);
  localparam logic [COUNT_BITS-1:0] LAST_SLOT = COUNT_BITS'(RATE_WORDS - 1);

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    full_q, full_d;
  logic [BLOCK_BITS-1:0]   out_q, out_d;

  logic [31:0] paddedWord;
  logic [31:0] writeWord;
  logic        accept;
  logic        write;
  logic        fillsBlock;

  padder1 u_padder1 (
    .in_i       (bus.in),
    .byte_num_i (bus.byte_num),
    .out_o      (paddedWord)
  );

  // Next-state logic. Acceptance uses the registered full flag, so a word
  // presented together with f_ack waits one cycle.
  always_comb begin
    accept     = (state_q == ABSORB) && bus.in_ready && !full_q;
    write      = accept || ((state_q == PAD) && !full_q);
    fillsBlock = write && (count_q == LAST_SLOT);

    if (state_q == PAD) begin
      writeWord = 32'h0;
    end else if (bus.is_last) begin
      writeWord = paddedWord;
    end else begin
      writeWord = bus.in;
    end
    // The closing bit shares the last slot with pad zeros or the last word.
    if (fillsBlock && ((state_q == PAD) || bus.is_last)) begin
      writeWord = writeWord | FINAL_BIT;
    end

    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    out_d   = out_q;

    if (full_q && bus.f_ack) begin
      count_d = '0;
      full_d  = 1'b0;
    end else if (write) begin
      out_d   = {out_q[BLOCK_BITS-33:0], writeWord};
      count_d = count_q + 1'b1;
      full_d  = fillsBlock;
      if ((state_q == ABSORB) && bus.is_last) begin
        // A last word that fills the block needs no padding cycles.
        state_d = fillsBlock ? DONE : PAD;
      end else if ((state_q == PAD) && fillsBlock) begin
        state_d = DONE;
      end
    end
  end

  // State, counter, full flag and block register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ABSORB;
      count_q <= '0;
      full_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      out_q   <= out_d;
    end
  end

  assign bus.buffer_full = full_q;
  assign bus.out_ready   = full_q;
  assign bus.out         = out_q;

endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder: self-checking bench for sha3_padder. Expected rate blocks
// are built from a reference padding model and queued when the message is
// driven; each block is popped and compared when out_ready is seen.
module tb_sha3_padder;

  import sha3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sha3_padder_if bus ();

  sha3_padder #(.RATE_WORDS(RATE_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [575:0] expQ[$];

  // Reference domain-byte insertion for the final word
  function automatic logic [31:0] padModel(input logic [31:0] d, input logic [1:0] n);
    case (n)
      2'd0: return 32'h06000000;
      2'd1: return {d[31:24], 24'h060000};
      2'd2: return {d[31:16], 16'h0600};
      default: return {d[31:8], 8'h06};
    endcase
  endfunction

  // Word 0 lands in the top 32 bits of the block
  function automatic logic [575:0] packBlock(input logic [31:0] w [18]);
    logic [575:0] b;
    b = '0;
    for (int i = 0; i < 18; i++) b[575-32*i -: 32] = w[i];
    return b;
  endfunction

  function automatic logic [575:0] emptyBlock();
    logic [31:0] w [18];
    for (int i = 0; i < 18; i++) w[i] = 32'h0;
    w[0]  = 32'h06000000;
    w[17] = 32'h00000080;
    return packBlock(w);
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.in       = 32'h0;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.byte_num = 2'd0;
    bus.f_ack    = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
  endtask

  // Present a word and hold it until buffer_full allows it to be taken
  task automatic sendWord(input logic [31:0] d, input logic last, input logic [1:0] n,
                          input string name);
    bit taken;
    taken = 1'b0;
    bus.in       = d;
    bus.is_last  = last;
    bus.byte_num = n;
    bus.in_ready = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = !bus.buffer_full;
      stepCycle();
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept: word %h never taken, buffer_full=%b expected 0", name, d, bus.buffer_full);
    end
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
  endtask

  // Wait for out_ready, then pop the next expected block and compare
  task automatic waitBlock(input string name);
    logic [575:0] exp;
    int cyc;
    cyc = 0;
    while (!bus.out_ready && cyc < 40) begin
      stepCycle();
      cyc++;
    end
    checks++;
    if (!bus.out_ready) begin
      errors++;
      $display("[TB] FAIL %s out_ready: got %b expected 1 within 40 cycles", name, bus.out_ready);
    end else if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: got a block, expected none queued", name);
    end else begin
      exp = expQ.pop_front();
      if (bus.out !== exp) begin
        errors++;
        $display("[TB] FAIL %s block: got %h expected %h", name, bus.out, exp);
      end
    end
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    #3;
    checks++;
    if (bus.out !== 576'h0) begin
      errors++;
      $display("[TB] FAIL reset out: got %h expected 0", bus.out);
    end
    checks++;
    if (bus.out_ready !== 1'b0 || bus.buffer_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset flags: got out_ready=%b buffer_full=%b expected 0/0", bus.out_ready, bus.buffer_full);
    end
    checks++;
    if (dut.state_q !== ABSORB || dut.count_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset state: got state=%0d count=%0d expected 0/0", dut.state_q, dut.count_q);
    end
    doReset();
  endtask

  task automatic test_empty();
    int cyc;
    doReset();
    expQ.push_back(emptyBlock());
    bus.in       = 32'hDEADBEEF;
    bus.is_last  = 1'b1;
    bus.byte_num = 2'd0;
    bus.in_ready = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 40 && !bus.out_ready; i++) begin
      stepCycle();
      cyc = i;
      if (i == 1) begin
        bus.in_ready = 1'b0;
        bus.is_last  = 1'b0;
      end
    end
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("[TB] FAIL empty latency: got %0d cycles expected 18", cyc);
    end
    waitBlock("empty");
    checks++;
    if (dut.state_q !== DONE) begin
      errors++;
      $display("[TB] FAIL empty state: got %0d expected %0d", dut.state_q, DONE);
    end
  endtask

  task automatic test_three_byte();
    logic [31:0] w [18];
    doReset();
    for (int i = 0; i < 18; i++) w[i] = 32'h0;
    w[0]  = padModel(32'h112233FF, 2'd3);
    w[17] = 32'h00000080;
    expQ.push_back(packBlock(w));
    sendWord(32'h112233FF, 1'b1, 2'd3, "three_byte");
    waitBlock("three_byte");
  endtask

  task automatic test_last_slot();
    logic [31:0] w [18];
    doReset();
    for (int i = 0; i < 17; i++) w[i] = 32'(i + 1);
    w[17] = padModel(32'hAABBCCDD, 2'd3) | 32'h00000080;
    expQ.push_back(packBlock(w));
    for (int i = 0; i < 17; i++) sendWord(32'(i + 1), 1'b0, 2'd0, "last_slot");
    sendWord(32'hAABBCCDD, 1'b1, 2'd3, "last_slot");
    checks++;
    if (bus.out_ready !== 1'b1 || dut.count_q !== 5'd18 || dut.state_q !== DONE) begin
      errors++;
      $display("[TB] FAIL last_slot direct: got out_ready=%b count=%0d state=%0d expected 1/18/%0d",
               bus.out_ready, dut.count_q, dut.state_q, DONE);
    end
    waitBlock("last_slot");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [18];
    logic [575:0] first;
    doReset();
    for (int i = 0; i < 18; i++) w[i] = 32'h100 + 32'(i);
    first = packBlock(w);
    expQ.push_back(first);
    expQ.push_back(emptyBlock());
    for (int i = 0; i < 18; i++) sendWord(32'h100 + 32'(i), 1'b0, 2'd0, "b2b");
    bus.in       = 32'h12345678;
    bus.is_last  = 1'b1;
    bus.byte_num = 2'd0;
    bus.in_ready = 1'b1;
    waitBlock("b2b_first");
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if (dut.count_q !== 5'd18 || bus.out !== first) begin
        errors++;
        $display("[TB] FAIL stall cycle %0d: got count=%0d out_changed=%b expected 18/0",
                 i, dut.count_q, bus.out !== first);
      end
    end
    bus.f_ack = 1'b1;
    stepCycle();
    bus.f_ack = 1'b0;
    checks++;
    if (bus.buffer_full !== 1'b0 || dut.count_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL f_ack clear: got buffer_full=%b count=%0d expected 0/0", bus.buffer_full, dut.count_q);
    end
    stepCycle();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    checks++;
    if (dut.count_q !== 5'd1 || bus.out[31:0] !== 32'h06000000) begin
      errors++;
      $display("[TB] FAIL pending accept: got count=%0d word=%h expected 1/06000000", dut.count_q, bus.out[31:0]);
    end
    waitBlock("b2b_second");
    checks++;
    if (dut.state_q !== DONE) begin
      errors++;
      $display("[TB] FAIL b2b state: got %0d expected %0d", dut.state_q, DONE);
    end
  endtask

  task automatic test_reset_in_pad();
    doReset();
    bus.in       = 32'h0;
    bus.is_last  = 1'b1;
    bus.byte_num = 2'd0;
    bus.in_ready = 1'b1;
    stepCycle();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    for (int i = 0; i < 8; i++) stepCycle();
    checks++;
    if (dut.state_q !== PAD || dut.count_q !== 5'd9) begin
      errors++;
      $display("[TB] FAIL pad position: got state=%0d count=%0d expected %0d/9", dut.state_q, dut.count_q, PAD);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out !== 576'h0 || bus.out_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async reset outputs: got out_ready=%b out=%h expected 0/0", bus.out_ready, bus.out);
    end
    checks++;
    if (dut.state_q !== ABSORB || dut.count_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL async reset state: got state=%0d count=%0d expected 0/0", dut.state_q, dut.count_q);
    end
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
    expQ.push_back(emptyBlock());
    sendWord(32'h0, 1'b1, 2'd0, "after_reset");
    waitBlock("after_reset");
  endtask

  // Scenario sequence and summary
  initial begin
    idleInputs();
    test_reset();
    test_empty();
    test_three_byte();
    test_last_slot();
    test_back_to_back();
    test_reset_in_pad();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
